// File: rtl/gate_enable_ctrl.sv
// rtl/gate_enable_ctrl.sv - clock-gate enable controller with wake/idle/drain FSM
// Optional wake-event statistics counter enabled by defining GATE_STATS_EN.
module gate_enable_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_sel,
   output logic        req_ready,
   input  logic        force_on,
   output logic        gate_en,
   output logic [1:0]  sel,
   output logic [31:0] data_out,
   output logic [1:0]  state_o,
   output logic [15:0] gate_wakes
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_WAKE  = 2'd1,
      ST_ON    = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);
   localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] wake_q, wake_d;
   logic [7:0] idle_q, idle_d;
   logic       xfer;

   assign req_ready = (state_q == ST_ON);
   assign xfer      = req_valid & req_ready;
   assign state_o   = state_q;

   always_comb begin
      state_d = state_q;
      wake_d  = wake_q;
      idle_d  = idle_q;
      case (state_q)
         ST_OFF: begin
            if (req_valid || force_on) begin
               state_d = ST_WAKE;
               wake_d  = WAKE_LOAD;
            end
         end
         ST_WAKE: begin
            if (wake_q == 4'd0) begin
               state_d = ST_ON;
               idle_d  = 8'd0;
            end else begin
               wake_d = wake_q - 4'd1;
            end
         end
         ST_ON: begin
            if (xfer || force_on) begin
               idle_d = 8'd0;
            end else if (idle_q == IDLE_LAST && !req_valid) begin
               state_d = ST_DRAIN;
            end else begin
               idle_d = idle_q + 8'd1;
            end
         end
         ST_DRAIN: begin
            // Late traffic reopens directly; the clock is still running.
            if (req_valid || force_on) begin
               state_d = ST_ON;
               idle_d  = 8'd0;
            end else begin
               state_d = ST_OFF;
            end
         end
         default: state_d = ST_OFF;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         wake_q   <= 4'd0;
         idle_q   <= 8'd0;
         gate_en  <= 1'b0;
         sel      <= 2'd0;
         data_out <= 32'd0;
      end else begin
         state_q <= state_d;
         wake_q  <= wake_d;
         idle_q  <= idle_d;
         // Registered decode keeps the enable glitch-free for the gating latch.
         gate_en <= (state_d != ST_OFF);
         if (xfer) begin
            sel      <= req_sel;
            data_out <= req_data;
         end
      end
   end

`ifdef GATE_STATS_EN
   logic [15:0] wakes_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wakes_q <= 16'd0;
      end else if (state_q == ST_OFF && state_d == ST_WAKE && wakes_q != 16'hFFFF) begin
         wakes_q <= wakes_q + 16'd1;
      end
   end

   assign gate_wakes = wakes_q;
`else
   assign gate_wakes = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_enable_ctrl.sv
// tb/tb_gate_enable_ctrl.sv - directed self-checking bench for gate_enable_ctrl
module tb_gate_enable_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_data = 32'd0;
   logic [1:0]  req_sel = 2'd0;
   logic        req_ready;
   logic        force_on = 1'b0;
   logic        gate_en;
   logic [1:0]  sel;
   logic [31:0] data_out;
   logic [1:0]  state_o;
   logic [15:0] gate_wakes;

   int n_checks = 0;
   int n_fail = 0;

`ifdef GATE_STATS_EN
   localparam logic [15:0] EXP_WAKES3 = 16'd3;
`else
   localparam logic [15:0] EXP_WAKES3 = 16'd0;
`endif

   gate_enable_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_sel    (req_sel),
      .req_ready  (req_ready),
      .force_on   (force_on),
      .gate_en    (gate_en),
      .sel        (sel),
      .data_out   (data_out),
      .state_o    (state_o),
      .gate_wakes (gate_wakes)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_state"}, 32'(state_o), 32'd0);
      check_eq({tag, "_gate"}, 32'(gate_en), 32'd0);
      check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
      check_eq({tag, "_sel"}, 32'(sel), 32'd0);
      check_eq({tag, "_data"}, data_out, 32'd0);
      check_eq({tag, "_wakes"}, 32'(gate_wakes), 32'd0);
   endtask

   initial begin
      logic bad;
      step(2);
      check_reset_vals("rst");
      rst_n = 1'b1;
      step(1);
      check_eq("idle_off", 32'(state_o), 32'd0);

      // Wake: edges 0..3
      req_valid = 1'b1; req_data = 32'hA5A5_0001; req_sel = 2'b01;
      step(1);
      check_eq("wake_gate_e0", 32'(gate_en), 32'd1);
      check_eq("wake_state_e0", 32'(state_o), 32'd1);
      check_eq("wake_ready_e0", 32'(req_ready), 32'd0);
      step(1);
      check_eq("wake_ready_e1", 32'(req_ready), 32'd0);
      step(1);
      check_eq("wake_ready_e2", 32'(req_ready), 32'd1);
      check_eq("wake_data_e2", data_out, 32'd0);
      step(1);
      check_eq("wake_data_e3", data_out, 32'hA5A5_0001);
      check_eq("wake_sel_e3", 32'(sel), 32'd1);

      // Burst of four back-to-back words then close
      for (int i = 0; i < 4; i++) begin
         req_data = 32'h1000_0000 + 32'(i);
         req_sel  = 2'(i);
         step(1);
         check_eq($sformatf("burst_data%0d", i), data_out, 32'h1000_0000 + 32'(i));
         check_eq($sformatf("burst_sel%0d", i), 32'(sel), 32'(i));
      end
      req_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check_eq($sformatf("close_state_t%0d", k), 32'(state_o),
                  (k < 4) ? 32'd2 : (k == 4) ? 32'd3 : 32'd0);
         check_eq($sformatf("close_gate_t%0d", k), 32'(gate_en), (k < 5) ? 32'd1 : 32'd0);
      end
      check_eq("close_hold_data", data_out, 32'h1000_0003);

      // Rescue from DRAIN
      req_valid = 1'b1; req_data = 32'hC0DE_0001; req_sel = 2'd2;
      step(3);
      check_eq("resc_ready", 32'(req_ready), 32'd1);
      step(1);
      check_eq("resc_data1", data_out, 32'hC0DE_0001);
      req_valid = 1'b0;
      step(4);
      check_eq("resc_drain", 32'(state_o), 32'd3);
      check_eq("resc_drain_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1; req_data = 32'hC0DE_0002; req_sel = 2'd3;
      step(1);
      check_eq("resc_on", 32'(state_o), 32'd2);
      check_eq("resc_on_ready", 32'(req_ready), 32'd1);
      check_eq("resc_hold", data_out, 32'hC0DE_0001);
      step(1);
      check_eq("resc_data2", data_out, 32'hC0DE_0002);
      check_eq("resc_sel2", 32'(sel), 32'd3);
      req_valid = 1'b0;
      step(5);
      check_eq("resc_off", 32'(state_o), 32'd0);

      // force_on held for 100 cycles
      force_on = 1'b1;
      step(1);
      check_eq("force_wake", 32'(state_o), 32'd1);
      step(2);
      check_eq("force_on_state", 32'(state_o), 32'd2);
      bad = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step(1);
         if (state_o != 2'd2 || gate_en != 1'b1) bad = 1'b1;
      end
      check_eq("force_hold", 32'(bad), 32'd0);
      force_on = 1'b0;
      step(4);
      check_eq("force_rel_drain", 32'(state_o), 32'd3);
      step(1);
      check_eq("force_rel_off", 32'(state_o), 32'd0);
      check_eq("force_rel_gate", 32'(gate_en), 32'd0);
      check_eq("wakes3", 32'(gate_wakes), 32'(EXP_WAKES3));

      // valid on the idle-limit cycle blocks DRAIN
      force_on = 1'b1;
      step(1);
      force_on = 1'b0;
      step(2);
      check_eq("lim_on", 32'(state_o), 32'd2);
      step(3);
      check_eq("lim_pre", 32'(state_o), 32'd2);
      req_valid = 1'b1; req_data = 32'hD000_0001; req_sel = 2'd1;
      step(1);
      check_eq("lim_blocked", 32'(state_o), 32'd2);
      check_eq("lim_data", data_out, 32'hD000_0001);

      // Asynchronous reset mid-burst
      req_data = 32'hD000_0002;
      rst_n = 1'b0;
      #1;
      check_reset_vals("arst");
      step(2);
      check_reset_vals("arst_hold");
      req_valid = 1'b0;
      rst_n = 1'b1;
      step(1);
      check_eq("arst_off", 32'(state_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
